// File: rtl/psum_accum_out_if.sv
// Handshake bundle between the adder tree, the psum accumulator/output stage
// and the downstream byte consumer. The slave modport is the accumulator's
// view; the master modport is the view of whoever drives Psum and takes beats.
interface psum_accum_out_if #(
    parameter int LANES      = 48,
    parameter int PSUM_W     = 18,
    parameter int BEAT_LANES = 8
);
    logic                      Psum_valid;
    logic [LANES*PSUM_W-1:0]   Psum;
    logic                      Psum_last;
    logic [4:0]                quant_shift;
    logic                      psum_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [BEAT_LANES*8-1:0]   out_data;
    logic                      out_last;

    modport master (
        output Psum_valid, Psum, Psum_last, quant_shift, out_ready,
        input  psum_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  Psum_valid, Psum, Psum_last, quant_shift, out_ready,
        output psum_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/psum_accum_out.sv
// Partial-sum accumulator and quantised output stage.
// Accumulates LANES signed PSUM_W-bit partial sums into ACC_W-bit lane
// registers over several input-channel passes. The pass flagged Psum_last
// ends the tile: each lane is shifted right arithmetically, clamped to
// 0..255 and streamed out BEAT_LANES bytes per beat.
// Build option: define PSUM_ACC_SAT_EN to make each accumulate saturate
// at the ACC_W signed limits instead of wrapping.
module psum_accum_out #(
    parameter int LANES      = 48,
    parameter int PSUM_W     = 18,
    parameter int ACC_W      = 24,
    parameter int BEAT_LANES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    psum_accum_out_if.slave   bus,
    output logic              drop_err
);
    localparam int BEATS = LANES / BEAT_LANES;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic signed [ACC_W-1:0]   acc     [LANES];
    logic signed [ACC_W-1:0]   acc_nxt [LANES];
    logic                      first;
    logic [4:0]                shift_q;
    logic [BCW-1:0]            beat_cnt;
    logic [BCW-1:0]            beat_nxt;
    logic [BEAT_LANES*8-1:0]   beat0_data;
    logic [BEAT_LANES*8-1:0]   beat_nxt_data;

    logic                      accept;
    logic                      tile_end;
    logic                      xfer;
    logic                      drain_done;

    // Sign-extend one partial-sum lane to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
        return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

    // Lane accumulate: wraps modulo 2^ACC_W, or clamps when saturation is built in.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
`ifdef PSUM_ACC_SAT_EN
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W])
                return {1'b1, {(ACC_W-1){1'b0}}};
            else
                return {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    // ReLU + arithmetic right shift + clamp to an unsigned byte.
    function automatic logic [7:0] quant_byte(
        input logic signed [ACC_W-1:0] a,
        input logic [4:0]              sh
    );
        logic signed [ACC_W-1:0] v;
        v = a >>> sh;
        if (v[ACC_W-1])
            return 8'd0;
        else if (|v[ACC_W-2:8])
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    assign accept     = bus.Psum_valid && bus.psum_ready;
    assign tile_end   = accept && bus.Psum_last;
    assign xfer       = bus.out_valid && bus.out_ready;
    assign drain_done = xfer && (beat_cnt == LAST_BEAT);
    assign beat_nxt   = beat_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_ACC;
        else
            state <= state_nxt;
    end

    // Next state: leave ACC on the last pass, return after the final beat transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:   if (tile_end)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_ACC;
            default:  state_nxt = ST_ACC;
        endcase
    end

    // FSM outputs: input side is open only while accumulating; beats are valid for the whole drain.
    always_comb begin
        bus.psum_ready = (state == ST_ACC);
        bus.out_valid  = (state == ST_DRAIN);
    end

    // Candidate accumulator values for the word on the bus (first pass loads, later passes add).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (first)
                acc_nxt[i] = sext_psum(bus.Psum[i*PSUM_W +: PSUM_W]);
            else
                acc_nxt[i] = acc_add(acc[i], sext_psum(bus.Psum[i*PSUM_W +: PSUM_W]));
        end
    end

    // Quantised beat contents: beat 0 straight from the closing accumulate, later beats from acc.
    always_comb begin
        int base;
        base          = 0;
        beat0_data    = '0;
        beat_nxt_data = '0;
        if (int'(beat_nxt) < BEATS)
            base = int'(beat_nxt) * BEAT_LANES;
        for (int k = 0; k < BEAT_LANES; k++) begin
            beat0_data[k*8 +: 8]    = quant_byte(acc_nxt[k], bus.quant_shift);
            beat_nxt_data[k*8 +: 8] = quant_byte(acc[base + k], shift_q);
        end
    end

    // ---- stage p0: lane accumulators, updated on every accepted pass ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++)
                acc[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++)
                acc[i] <= acc_nxt[i];
        end
    end

    // Tile control: first-pass flag, latched shift, beat counter and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first    <= 1'b1;
            shift_q  <= '0;
            beat_cnt <= '0;
            drop_err <= 1'b0;
        end else begin
            if (bus.Psum_valid && !bus.psum_ready)
                drop_err <= 1'b1;
            if (accept)
                first <= 1'b0;
            if (drain_done)
                first <= 1'b1;
            if (tile_end) begin
                shift_q  <= bus.quant_shift;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_nxt;
            end
        end
    end

    // ---- stage p1: registered output beat, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data <= '0;
            bus.out_last <= 1'b0;
        end else if (tile_end) begin
            bus.out_data <= beat0_data;
            bus.out_last <= (BEATS == 1);
        end else if (drain_done) begin
            bus.out_data <= '0;
            bus.out_last <= 1'b0;
        end else if (xfer) begin
            bus.out_data <= beat_nxt_data;
            bus.out_last <= (beat_nxt == LAST_BEAT);
        end
    end
endmodule

// File: tb/tb_psum_accum_out.sv
// Directed testbench for psum_accum_out: reset, single pass, multi-pass
// accumulate, saturation/wrap, output backpressure, dropped input words
// and reset in the middle of a drain.
module tb_psum_accum_out;
    localparam int LANES  = 48;
    localparam int PSUM_W = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drop_err;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    psum_accum_out_if #(.LANES(LANES), .PSUM_W(PSUM_W), .BEAT_LANES(8)) bus ();

    psum_accum_out #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(24), .BEAT_LANES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .drop_err (drop_err)
    );

    // Every lane holds the same value.
    function automatic logic [LANES*PSUM_W-1:0] fill(input int v);
        logic [LANES*PSUM_W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*PSUM_W +: PSUM_W] = PSUM_W'(v);
        return w;
    endfunction

    // Lane i holds a*i + b.
    function automatic logic [LANES*PSUM_W-1:0] ramp(input int a, input int b);
        logic [LANES*PSUM_W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*PSUM_W +: PSUM_W] = PSUM_W'(a*i + b);
        return w;
    endfunction

    // Present one pass for one cycle; returns on the falling edge after the accept edge.
    task automatic drive_pass(input logic [LANES*PSUM_W-1:0] w, input logic last, input logic [4:0] sh);
        @(negedge clk);
        bus.Psum_valid  = 1'b1;
        bus.Psum        = w;
        bus.Psum_last   = last;
        bus.quant_shift = sh;
        @(negedge clk);
        bus.Psum_valid  = 1'b0;
        bus.Psum_last   = 1'b0;
    endtask

    task automatic test_reset();
        bus.Psum_valid  = 1'b0;
        bus.Psum        = '0;
        bus.Psum_last   = 1'b0;
        bus.quant_shift = '0;
        bus.out_ready   = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.psum_ready !== 1'b1) begin errors++; $display("FAIL reset_psum_ready: got %b want 1", bus.psum_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
        checks++;
        if (bus.out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.psum_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.psum_ready); end
    endtask

    task automatic test_single_pass();
        bus.out_ready = 1'b1;
        drive_pass(fill(100), 1'b1, 5'd0);
        checks++;
        if (bus.psum_ready !== 1'b0) begin errors++; $display("FAIL single_ready_low: got %b want 0", bus.psum_ready); end
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h6464646464646464) begin
                errors++;
                $display("FAIL single_beat%0d: got valid=%b data=%h want valid=1 data=6464646464646464", b, bus.out_valid, bus.out_data);
            end
            checks++;
            if (bus.out_last !== (b == 5)) begin errors++; $display("FAIL single_last%0d: got %b want %b", b, bus.out_last, (b == 5)); end
            @(negedge clk);
        end
        checks++;
        if (bus.psum_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got ready=%b valid=%b want ready=1 valid=0", bus.psum_ready, bus.out_valid);
        end
    endtask

    task automatic test_three_pass();
        logic [63:0] want;
        bus.out_ready = 1'b1;
        drive_pass(ramp(1, 0), 1'b0, 5'd0);
        drive_pass(ramp(1, 0), 1'b0, 5'd0);
        drive_pass(ramp(1, 0), 1'b1, 5'd1);
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++) want[k*8 +: 8] = 8'((3 * (8*b + k)) >> 1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin
                errors++;
                $display("FAIL three_beat%0d: got valid=%b data=%h want valid=1 data=%h", b, bus.out_valid, bus.out_data, want);
            end
            if (b == 5) begin
                checks++;
                if (bus.out_data[63:56] !== 8'd70) begin errors++; $display("FAIL three_lane47: got %0d want 70", bus.out_data[63:56]); end
            end
            @(negedge clk);
        end
        // Odd lanes negative (-5) must clamp to 0; even lanes pass through.
        begin
            logic [LANES*PSUM_W-1:0] w;
            w = ramp(1, 0);
            for (int i = 1; i < LANES; i += 2) w[i*PSUM_W +: PSUM_W] = PSUM_W'(-5);
            drive_pass(w, 1'b1, 5'd0);
        end
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++) want[k*8 +: 8] = (k % 2 == 1) ? 8'd0 : 8'(8*b + k);
            checks++;
            if (bus.out_data !== want) begin
                errors++;
                $display("FAIL relu_beat%0d: got %h want %h", b, bus.out_data, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] want;
        bus.out_ready = 1'b1;
        drive_pass(fill(131071), 1'b0, 5'd0);
        drive_pass(fill(131071), 1'b1, 5'd4);
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (bus.out_data !== {8{8'hFF}}) begin errors++; $display("FAIL sat2_beat%0d: got %h want ffffffffffffffff", b, bus.out_data); end
            @(negedge clk);
        end
        // 70 passes of 131071 = 9174970, beyond the 24-bit signed range.
`ifdef PSUM_ACC_SAT_EN
        want = {8{8'hFF}};
`else
        want = 64'h0;
`endif
        for (int p = 0; p < 69; p++) drive_pass(fill(131071), 1'b0, 5'd0);
        drive_pass(fill(131071), 1'b1, 5'd4);
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin
                errors++;
                $display("FAIL ovf70_beat%0d: got valid=%b data=%h want valid=1 data=%h", b, bus.out_valid, bus.out_data, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] want;
        int beat;
        int stall;
        beat  = 0;
        stall = 0;
        bus.out_ready = 1'b1;
        // Lane i = 4i+3 with shift 2 gives byte i.
        drive_pass(ramp(4, 3), 1'b1, 5'd2);
        for (int cyc = 0; cyc < 40 && beat < 6; cyc++) begin
            for (int k = 0; k < 8; k++) want[k*8 +: 8] = 8'(8*beat + k);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want || bus.out_last !== (beat == 5)) begin
                errors++;
                $display("FAIL bp_beat%0d_cyc%0d: got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         beat, cyc, bus.out_valid, bus.out_data, bus.out_last, want, (beat == 5));
            end
            if (beat == 2 && stall < 5) begin
                bus.out_ready = 1'b0;
                stall++;
            end else begin
                bus.out_ready = 1'b1;
                beat++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        checks++;
        if (bus.psum_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: got ready=%b valid=%b want ready=1 valid=0", bus.psum_ready, bus.out_valid);
        end
    endtask

    task automatic test_drop();
        bus.out_ready = 1'b1;
        checks++;
        if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_before: got %b want 0", drop_err); end
        drive_pass(fill(50), 1'b1, 5'd0);
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (bus.out_data !== {8{8'h32}}) begin errors++; $display("FAIL drop_beat%0d: got %h want 3232323232323232", b, bus.out_data); end
            if (b >= 2) begin
                checks++;
                if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_flag%0d: got %b want 1", b, drop_err); end
            end
            if (b == 1) begin
                bus.Psum_valid = 1'b1;
                bus.Psum       = fill(9);
                bus.Psum_last  = 1'b1;
            end else begin
                bus.Psum_valid = 1'b0;
                bus.Psum_last  = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (drop_err !== 1'b1 || bus.psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_after: got err=%b ready=%b want err=1 ready=1", drop_err, bus.psum_ready);
        end
        drive_pass(fill(7), 1'b1, 5'd0);
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (bus.out_data !== {8{8'h07}}) begin errors++; $display("FAIL next_tile_beat%0d: got %h want 0707070707070707", b, bus.out_data); end
            @(negedge clk);
        end
        checks++;
        if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", drop_err); end
    endtask

    task automatic test_reset_mid_drain();
        bus.out_ready = 1'b1;
        drive_pass(fill(20), 1'b1, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ctrl: got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.psum_ready);
        end
        checks++;
        if (bus.out_data !== 64'h0 || bus.out_last !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs: got data=%h last=%b err=%b want data=0 last=0 err=0", bus.out_data, bus.out_last, drop_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_pass(fill(3), 1'b1, 5'd0);
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== {8{8'h03}}) begin
                errors++;
                $display("FAIL midrst_next_beat%0d: got valid=%b data=%h want valid=1 data=0303030303030303", b, bus.out_valid, bus.out_data);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pass();
        test_three_pass();
        test_saturation();
        test_backpressure();
        test_drop();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
